// File: rtl/ob_table_cnt_acc_if.sv
// ob_table_cnt_acc_if: beat input and result output handshakes of the carry-save count accumulator
interface ob_table_cnt_acc_if #(
  parameter int W     = 32,
  parameter int CNT_W = 40
);
  logic             in_vld;
  logic             in_rdy;
  logic [W-1:0]     in_s;
  logic [W-1:0]     in_c;
  logic             in_last;
  logic             out_vld;
  logic             out_rdy;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;
  modport master (output in_vld, in_s, in_c, in_last, out_rdy, input in_rdy, out_vld, out_cnt, out_ovf);
  modport slave (input in_vld, in_s, in_c, in_last, out_rdy, output in_rdy, out_vld, out_cnt, out_ovf);
endinterface

// File: rtl/ob_table_cnt_acc.sv
// ob_table_cnt_acc: carry-save running total over a table scan, one saturating carry-propagate add per scan
module ob_table_cnt_acc #(
  parameter int W     = 32,
  parameter int CNT_W = 40
) (
  input logic               clk,
  input logic               arst_n,
  ob_table_cnt_acc_if.slave b
);
  if (CNT_W < W + 1) begin : g_bad_width
    $error("ob_table_cnt_acc: CNT_W must be >= W+1");
  end
  typedef enum logic [2:0] {INIT, IDLE, ACC, CPA, OUT} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] acc_s, acc_c, xs, xc, s1, m1, s2, m2;
  logic [CNT_W:0]   cpa;
  logic             ovf_q, cpa_ovf, accept, retire;
  assign accept  = b.in_vld & b.in_rdy;
  assign retire  = b.out_vld & b.out_rdy;
  assign xs      = {{(CNT_W-W){1'b0}}, b.in_s};
  assign xc      = {{(CNT_W-W){1'b0}}, b.in_c};
  // Two cascaded 3:2 stages; each majority vector's top bit is the carry lost by the <<1
  assign s1      = acc_s ^ acc_c ^ xs;
  assign m1      = (acc_s & acc_c) | (acc_s & xs) | (acc_c & xs);
  assign s2      = s1 ^ (m1 << 1) ^ xc;
  assign m2      = (s1 & (m1 << 1)) | (s1 & xc) | ((m1 << 1) & xc);
  assign cpa     = {1'b0, acc_s} + {1'b0, acc_c};
  assign cpa_ovf = ovf_q | cpa[CNT_W];
  always_comb begin
    state_n = state;
    case (state)
      INIT:      state_n = IDLE;
      IDLE, ACC: state_n = accept ? (b.in_last ? CPA : ACC) : state;
      CPA:       state_n = OUT;
      OUT:       state_n = retire ? IDLE : OUT;
      default:   state_n = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= INIT;
      acc_s     <= '0;
      acc_c     <= '0;
      ovf_q     <= 1'b0;
      b.in_rdy  <= 1'b0;
      b.out_vld <= 1'b0;
      b.out_cnt <= '0;
      b.out_ovf <= 1'b0;
    end else begin
      state     <= state_n;
      b.in_rdy  <= (state_n == IDLE) || (state_n == ACC);
      b.out_vld <= state_n == OUT;
      if (accept) begin
        acc_s <= s2;
        acc_c <= m2 << 1;
        ovf_q <= ovf_q | m1[CNT_W-1] | m2[CNT_W-1];
      end
      if (state == CPA) begin
        b.out_cnt <= cpa_ovf ? '1 : cpa[CNT_W-1:0];
        b.out_ovf <= cpa_ovf;
      end
      if (state == OUT && retire) begin
        acc_s <= '0;
        acc_c <= '0;
        ovf_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ob_table_cnt_acc.sv
// tb_ob_table_cnt_acc: directed vectors with hand-computed totals for the count accumulator
module tb_ob_table_cnt_acc;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;
  ob_table_cnt_acc_if #(.W(32), .CNT_W(40)) a ();
  ob_table_cnt_acc_if #(.W(32), .CNT_W(33)) n ();
  ob_table_cnt_acc #(.W(32), .CNT_W(40)) dut (.clk(clk), .arst_n(arst_n), .b(a.slave));
  ob_table_cnt_acc #(.W(32), .CNT_W(33)) dut33 (.clk(clk), .arst_n(arst_n), .b(n.slave));
  int n_chk = 0;
  int n_err = 0;
  logic [39:0] cnt;
  logic        ovf;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [31:0] s, c, input logic last, input int gap);
    a.in_vld = 1'b0;
    repeat (gap) @(negedge clk);
    a.in_vld  = 1'b1;
    a.in_s    = s;
    a.in_c    = c;
    a.in_last = last;
    for (int k = 0; k < 50 && !a.in_rdy; k++) @(negedge clk);
    chk("send_rdy", a.in_rdy, 1);
    @(negedge clk);
    a.in_vld = 1'b0;
  endtask
  task automatic get_res(output logic [39:0] c, output logic o);
    for (int k = 0; k < 50 && !a.out_vld; k++) @(negedge clk);
    chk("res_vld", a.out_vld, 1);
    c = a.out_cnt;
    o = a.out_ovf;
  endtask
  task automatic retire();
    a.out_rdy = 1'b1;
    @(negedge clk);
    a.out_rdy = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    {a.in_vld, a.in_s, a.in_c, a.in_last, a.out_rdy} = '0;
    {n.in_vld, n.in_s, n.in_c, n.in_last, n.out_rdy} = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", a.in_rdy, 0);
    chk("rst_vld", a.out_vld, 0);
    chk("rst_cnt", a.out_cnt, 0);
    chk("rst_ovf", a.out_ovf, 0);
    arst_n = 1'b1;
    #1 chk("rel_rdy_low", a.in_rdy, 0);
    @(negedge clk);
    chk("rel_rdy_high", a.in_rdy, 1);
    // single beat: CPA cycle then result
    send(32'd5, 32'd6, 1'b1, 0);
    chk("t1_cpa_vld", a.out_vld, 0);
    chk("t1_cpa_rdy", a.in_rdy, 0);
    @(negedge clk);
    chk("t1_vld", a.out_vld, 1);
    chk("t1_cnt", a.out_cnt, 11);
    chk("t1_ovf", a.out_ovf, 0);
    retire();
    chk("t1_retired", a.out_vld, 0);
    chk("t1_rearm", a.in_rdy, 1);
    // carry into bit 32 without overflow
    send(32'd1, 32'd2, 1'b0, 0);
    send(32'd3, 32'd4, 1'b0, 0);
    send(32'd100, 32'd0, 1'b0, 0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 0);
    get_res(cnt, ovf);
    chk("t2_cnt", cnt, 64'h2_0000_006B);
    chk("t2_ovf", ovf, 0);
    retire();
    // 33-bit accumulator overflows on two full beats
    n.in_vld  = 1'b1;
    n.in_s    = '1;
    n.in_c    = '1;
    n.in_last = 1'b0;
    chk("t3_rdy", n.in_rdy, 1);
    @(negedge clk);
    n.in_last = 1'b1;
    @(negedge clk);
    n.in_vld = 1'b0;
    for (int k = 0; k < 50 && !n.out_vld; k++) @(negedge clk);
    chk("t3_vld", n.out_vld, 1);
    chk("t3_ovf", n.out_ovf, 1);
    chk("t3_cnt", n.out_cnt, 64'h1_FFFF_FFFF);
    n.out_rdy = 1'b1;
    @(negedge clk);
    n.out_rdy = 1'b0;
    // result stalled 5 cycles while upstream offers a beat
    send(32'd7, 32'd8, 1'b1, 0);
    get_res(cnt, ovf);
    chk("t4_cnt", cnt, 15);
    a.in_vld  = 1'b1;
    a.in_s    = 32'd1000;
    a.in_c    = 32'd1000;
    a.in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_vld", a.out_vld, 1);
      chk("t4_hold_cnt", a.out_cnt, 15);
      chk("t4_hold_ovf", a.out_ovf, 0);
      chk("t4_hold_rdy", a.in_rdy, 0);
    end
    a.in_vld = 1'b0;
    retire();
    chk("t4_retired", a.out_vld, 0);
    chk("t4_rearm", a.in_rdy, 1);
    // reset mid-scan
    send(32'd1, 32'd1, 1'b0, 0);
    send(32'd2, 32'd2, 1'b0, 0);
    arst_n = 1'b0;
    #1;
    chk("t5_rdy", a.in_rdy, 0);
    chk("t5_vld", a.out_vld, 0);
    chk("t5_cnt", a.out_cnt, 0);
    chk("t5_ovf", a.out_ovf, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    // reset mid-OUT
    send(32'd9, 32'd9, 1'b1, 0);
    get_res(cnt, ovf);
    chk("t5_pre_cnt", cnt, 18);
    arst_n = 1'b0;
    #1;
    chk("t5_out_vld", a.out_vld, 0);
    chk("t5_out_cnt", a.out_cnt, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    send(32'd5, 32'd6, 1'b1, 0);
    get_res(cnt, ovf);
    chk("t5_rerun_cnt", cnt, 11);
    chk("t5_rerun_ovf", ovf, 0);
    retire();
    // gapped beats, out_rdy tied high, back-to-back scans
    a.out_rdy = 1'b1;
    send(32'd1, 32'd2, 1'b0, $urandom_range(0, 4));
    send(32'd3, 32'd4, 1'b0, $urandom_range(0, 4));
    send(32'd100, 32'd0, 1'b0, $urandom_range(0, 4));
    send(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, $urandom_range(0, 4));
    get_res(cnt, ovf);
    chk("t6_cnt_a", cnt, 64'h2_0000_006B);
    chk("t6_ovf_a", ovf, 0);
    send(32'd10, 32'd20, 1'b0, $urandom_range(0, 4));
    send(32'd30, 32'd40, 1'b1, $urandom_range(0, 4));
    get_res(cnt, ovf);
    chk("t6_cnt_b", cnt, 100);
    chk("t6_ovf_b", ovf, 0);
    @(negedge clk);
    chk("t6_retired", a.out_vld, 0);
    a.out_rdy = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
